// File: rtl/nrisc_wishbone_slave_ram_if.sv
// Wishbone classic bus bundle between the NRISC-aurora master and its data-RAM slave.
// Latency: none (wires only).
// Backpressure: the slave stalls the master by withholding ACK/ERR/RTY.
//
// Signals: CYC_IN/STRBIN request, WREN (0 write / 1 read), ADDR_IN, SEL byte lanes,
// DATAIN write data, TGAIN tag; DATAOUT/TGDOUT/ACK/ERR/RTY back from the slave.
// WSHSLV_HOLD exists only when NRISC_WSHSLV_RTY_EN is defined.
interface nrisc_wishbone_slave_ram_if #(
    parameter int TAM = 16
);
    logic             WSHSLV_CYC_IN;
    logic             WSHSLV_STRBIN;
    logic             WSHSLV_WREN;
    logic [TAM-1:0]   WSHSLV_ADDR_IN;
    logic [TAM/8-1:0] WSHSLV_SEL;
    logic [TAM-1:0]   WSHSLV_DATAIN;
    logic [7:0]       WSHSLV_TGAIN;
`ifdef NRISC_WSHSLV_RTY_EN
    logic             WSHSLV_HOLD;
`endif
    logic [TAM-1:0]   WSHSLV_DATAOUT;
    logic [7:0]       WSHSLV_TGDOUT;
    logic             WSHSLV_ACK;
    logic             WSHSLV_ERR;
    logic             WSHSLV_RTY;

`ifdef NRISC_WSHSLV_RTY_EN
    modport master (
        output WSHSLV_CYC_IN, WSHSLV_STRBIN, WSHSLV_WREN, WSHSLV_ADDR_IN,
               WSHSLV_SEL, WSHSLV_DATAIN, WSHSLV_TGAIN, WSHSLV_HOLD,
        input  WSHSLV_DATAOUT, WSHSLV_TGDOUT, WSHSLV_ACK, WSHSLV_ERR, WSHSLV_RTY
    );
    modport slave (
        input  WSHSLV_CYC_IN, WSHSLV_STRBIN, WSHSLV_WREN, WSHSLV_ADDR_IN,
               WSHSLV_SEL, WSHSLV_DATAIN, WSHSLV_TGAIN, WSHSLV_HOLD,
        output WSHSLV_DATAOUT, WSHSLV_TGDOUT, WSHSLV_ACK, WSHSLV_ERR, WSHSLV_RTY
    );
`else
    modport master (
        output WSHSLV_CYC_IN, WSHSLV_STRBIN, WSHSLV_WREN, WSHSLV_ADDR_IN,
               WSHSLV_SEL, WSHSLV_DATAIN, WSHSLV_TGAIN,
        input  WSHSLV_DATAOUT, WSHSLV_TGDOUT, WSHSLV_ACK, WSHSLV_ERR, WSHSLV_RTY
    );
    modport slave (
        input  WSHSLV_CYC_IN, WSHSLV_STRBIN, WSHSLV_WREN, WSHSLV_ADDR_IN,
               WSHSLV_SEL, WSHSLV_DATAIN, WSHSLV_TGAIN,
        output WSHSLV_DATAOUT, WSHSLV_TGDOUT, WSHSLV_ACK, WSHSLV_ERR, WSHSLV_RTY
    );
`endif
endinterface

// File: rtl/nrisc_wishbone_slave_ram.sv
// Wishbone classic slave wrapping the on-chip data RAM (byte-lane writes, full-word reads).
// Latency: request at edge 0 -> ACK in cycle WAIT_STATES+1; ERR/RTY in cycle 1.
// Backpressure: master holds CYC/STB until ACK/ERR/RTY; dropping them during WAIT aborts.
//
// Ports: WSHSLV_CLKIN clock (rising edge), WSHSLV_RSTIN synchronous active-low reset,
// wb = slave modport of nrisc_wishbone_slave_ram_if carrying the Wishbone signals.
// Optional macro NRISC_WSHSLV_RTY_EN: adds WSHSLV_HOLD and retry termination; otherwise RTY is 0.
module nrisc_wishbone_slave_ram #(
    parameter int TAM         = 16,
    parameter int N_DData     = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                          WSHSLV_CLKIN,
    input  logic                          WSHSLV_RSTIN,
    nrisc_wishbone_slave_ram_if.slave     wb
);
    localparam int SELW  = TAM / 8;
    localparam int DEPTH = 1 << N_DData;
    localparam logic [3:0] CNT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_TERM
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wren_q, wren_d;
    logic [N_DData-1:0]  idx_q, idx_d;
    logic [SELW-1:0]     sel_q, sel_d;
    logic [TAM-1:0]      data_q, data_d;
    logic [7:0]          tag_q, tag_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                rty_q, rty_d;
    logic [TAM-1:0]      dout_q, dout_d;
    logic [7:0]          tgd_q, tgd_d;

    logic [TAM-1:0]      ram_q [DEPTH];

    logic                req;
    logic                hold;
    logic                addr_oor;
    logic                wr_commit;
    logic                cur_wren;
    logic [N_DData-1:0]  cur_idx;
    logic [SELW-1:0]     cur_sel;
    logic [TAM-1:0]      cur_dat;
    logic [7:0]          cur_tag;

    assign req      = wb.WSHSLV_CYC_IN & wb.WSHSLV_STRBIN;
    assign addr_oor = (wb.WSHSLV_ADDR_IN >> N_DData) != '0;
`ifdef NRISC_WSHSLV_RTY_EN
    assign hold = wb.WSHSLV_HOLD;
`else
    assign hold = 1'b0;
`endif

    // With zero wait states the ACK decision is taken in IDLE, before anything is
    // latched, so the transfer has to use the live bus values in that state.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_wren = wb.WSHSLV_WREN;
            cur_idx  = wb.WSHSLV_ADDR_IN[N_DData-1:0];
            cur_sel  = wb.WSHSLV_SEL;
            cur_dat  = wb.WSHSLV_DATAIN;
            cur_tag  = wb.WSHSLV_TGAIN;
        end else begin
            cur_wren = wren_q;
            cur_idx  = idx_q;
            cur_sel  = sel_q;
            cur_dat  = data_q;
            cur_tag  = tag_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wren_d    = wren_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        data_d    = data_q;
        tag_d     = tag_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rty_d     = 1'b0;
        dout_d    = '0;
        tgd_d     = '0;
        wr_commit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    wren_d = wb.WSHSLV_WREN;
                    idx_d  = wb.WSHSLV_ADDR_IN[N_DData-1:0];
                    sel_d  = wb.WSHSLV_SEL;
                    data_d = wb.WSHSLV_DATAIN;
                    tag_d  = wb.WSHSLV_TGAIN;
                    if (addr_oor) begin
                        // Out of range wins over HOLD.
                        state_d = ST_TERM;
                        err_d   = 1'b1;
                        tgd_d   = cur_tag;
                    end else if (hold) begin
                        state_d = ST_TERM;
                        rty_d   = 1'b1;
                        tgd_d   = cur_tag;
                    end else if (WAIT_STATES == 0) begin
                        state_d = ST_TERM;
                        ack_d   = 1'b1;
                        tgd_d   = cur_tag;
                        if (cur_wren) dout_d = ram_q[cur_idx];
                        else          wr_commit = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    // Master gave up: no write, no termination pulse.
                    state_d = ST_IDLE;
                end else if (hold) begin
                    state_d = ST_TERM;
                    rty_d   = 1'b1;
                    tgd_d   = cur_tag;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_TERM;
                    ack_d   = 1'b1;
                    tgd_d   = cur_tag;
                    if (cur_wren) dout_d = ram_q[cur_idx];
                    else          wr_commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_TERM: begin
                // Termination cycle never accepts a new request.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge WSHSLV_CLKIN) begin
        if (!WSHSLV_RSTIN) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wren_q  <= 1'b0;
            idx_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            tag_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            dout_q  <= '0;
            tgd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wren_q  <= wren_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            dout_q  <= dout_d;
            tgd_q   <= tgd_d;
        end
    end

    // RAM is never cleared; reset only blocks a write that would land on the same edge.
    always_ff @(posedge WSHSLV_CLKIN) begin
        if (WSHSLV_RSTIN && wr_commit) begin
            for (int i = 0; i < SELW; i++) begin
                if (cur_sel[i]) ram_q[cur_idx][8*i +: 8] <= cur_dat[8*i +: 8];
            end
        end
    end

    assign wb.WSHSLV_ACK     = ack_q;
    assign wb.WSHSLV_ERR     = err_q;
    assign wb.WSHSLV_RTY     = rty_q;
    assign wb.WSHSLV_DATAOUT = dout_q;
    assign wb.WSHSLV_TGDOUT  = tgd_q;
endmodule
